// File: rtl/nat_arb_pkg.sv
// nat_arb_pkg: shared state, client-count and client-index types for nat_mem_arb
package nat_arb_pkg;
  localparam int NCLIENT = 2;
  typedef logic [$clog2(NCLIENT)-1:0] client_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RWAIT, ARB_RESP} arb_state_t;
endpackage

// File: rtl/nat_arb_rr.sv
// nat_arb_rr: two-requester round-robin picker; NAT_MEM_ARB_FIXED_PRIO_EN bypasses it to fixed priority (client 0 first)
module nat_arb_rr
  import nat_arb_pkg::*;
(
  input  logic               aclk_i,
  input  logic               aresetn_i,
  input  logic [NCLIENT-1:0] i_req,
  input  logic               i_upd,
  output client_t            o_gnt
);
`ifdef NAT_MEM_ARB_FIXED_PRIO_EN
  assign o_gnt = client_t'(~i_req[0]);
`else
  client_t r_last;
  // r_last only moves on contested grants, so a lone requester never steals the next tie
  assign o_gnt = (&i_req) ? ~r_last : client_t'(~i_req[0]);
  always_ff @(posedge aclk_i or negedge aresetn_i)
    if (!aresetn_i) r_last <= client_t'(1);
    else if (i_upd) r_last <= o_gnt;
`endif
endmodule

// File: rtl/nat_mem_arb.sv
// nat_mem_arb: two-client native memory arbiter, one op outstanding; NAT_MEM_ARB_FIXED_PRIO_EN selects fixed priority
module nat_mem_arb
  import nat_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NATIVE_DW = 256
) (
  input  logic                               aclk_i,
  input  logic                               aresetn_i,
  input  logic [NCLIENT-1:0]                 c_write_valid_i,
  input  logic [NCLIENT-1:0][ADDR_W-1:0]     c_write_addr_i,
  input  logic [NCLIENT-1:0][NATIVE_DW-1:0]  c_write_data_i,
  input  logic [NCLIENT-1:0]                 c_read_valid_i,
  input  logic [NCLIENT-1:0][ADDR_W-1:0]     c_read_addr_i,
  output logic [NCLIENT-1:0]                 c_read_valid_o,
  output logic [ADDR_W-1:0]                  c_read_addr_o,
  output logic [NATIVE_DW-1:0]               c_read_data_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [ADDR_W-1:0]                  mem_addr_o,
  output logic [NATIVE_DW-1:0]               mem_wdata_o,
  input  logic                               mem_ready_i,
  input  logic                               mem_rvalid_i,
  input  logic [NATIVE_DW-1:0]               mem_rdata_i,
  output logic [NCLIENT-1:0]                 ovf_o
);
  arb_state_t                        r_state;
  client_t                           r_owner, w_gnt;
  logic [NCLIENT-1:0]                r_wv, r_rv, r_ovf, r_rvo;
  logic [NCLIENT-1:0][ADDR_W-1:0]    r_wa, r_ra;
  logic [NCLIENT-1:0][NATIVE_DW-1:0] r_wd;
  logic                              r_req, r_we;
  logic [ADDR_W-1:0]                 r_addr, r_rd_addr;
  logic [NATIVE_DW-1:0]              r_wdata, r_rd_data;
  logic [NCLIENT-1:0]                w_pend, w_own, w_clr_w, w_clr_r, w_cap_w, w_cap_r, w_drop;
  logic                              w_acc;

  assign w_pend  = r_wv | r_rv;
  assign w_own   = NCLIENT'(1) << r_owner;
  assign w_acc   = r_req & mem_ready_i;
  assign w_clr_w = (w_acc & r_we) ? w_own : '0;
  assign w_clr_r = (w_acc & ~r_we) ? w_own : '0;
  // a slot being freed this edge can take a new pulse; a busy slot drops it
  assign w_cap_w = c_write_valid_i & (~r_wv | w_clr_w);
  assign w_cap_r = c_read_valid_i & (~r_rv | w_clr_r);
  assign w_drop  = (c_write_valid_i & r_wv & ~w_clr_w) | (c_read_valid_i & r_rv & ~w_clr_r);

  nat_arb_rr u_rr (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .i_req     (w_pend),
    .i_upd     ((r_state == ARB_IDLE) & (&w_pend)),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_wv  <= '0;
      r_rv  <= '0;
      r_wa  <= '0;
      r_ra  <= '0;
      r_wd  <= '0;
      r_ovf <= '0;
    end else begin
      r_wv  <= (r_wv & ~w_clr_w) | w_cap_w;
      r_rv  <= (r_rv & ~w_clr_r) | w_cap_r;
      r_ovf <= r_ovf | w_drop;
      for (int c = 0; c < NCLIENT; c++) begin
        if (w_cap_w[c]) begin
          r_wa[c] <= c_write_addr_i[c];
          r_wd[c] <= c_write_data_i[c];
        end
        if (w_cap_r[c]) r_ra[c] <= c_read_addr_i[c];
      end
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state   <= ARB_IDLE;
      r_owner   <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvo     <= '0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: if (|w_pend) begin
          r_owner <= w_gnt;
          r_we    <= r_wv[w_gnt];
          r_addr  <= r_wv[w_gnt] ? r_wa[w_gnt] : r_ra[w_gnt];
          r_wdata <= r_wv[w_gnt] ? r_wd[w_gnt] : '0;
          r_req   <= 1'b1;
          r_state <= ARB_REQ;
        end
        ARB_REQ: if (mem_ready_i) begin
          r_req   <= 1'b0;
          r_state <= r_we ? ARB_IDLE : ARB_RWAIT;
        end
        ARB_RWAIT: if (mem_rvalid_i) begin
          r_rd_addr <= r_addr;
          r_rd_data <= mem_rdata_i;
          r_rvo     <= w_own;
          r_state   <= ARB_RESP;
        end
        ARB_RESP: begin
          r_rvo   <= '0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign c_read_valid_o = r_rvo;
  assign c_read_addr_o  = r_rd_addr;
  assign c_read_data_o  = r_rd_data;
  assign mem_req_o      = r_req;
  assign mem_we_o       = r_we;
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign ovf_o          = r_ovf;
endmodule

// File: tb/tb_nat_mem_arb.sv
// tb_nat_mem_arb: table-driven vectors plus directed corner sequences for nat_mem_arb
module tb_nat_mem_arb;
  localparam int AW = 32;
  localparam int DW = 256;
`ifdef NAT_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic                   aclk_i = 1'b0;
  logic                   aresetn_i = 1'b0;
  logic [1:0]             c_write_valid_i, c_read_valid_i, c_read_valid_o, ovf_o;
  logic [1:0][AW-1:0]     c_write_addr_i, c_read_addr_i;
  logic [1:0][DW-1:0]     c_write_data_i;
  logic [AW-1:0]          c_read_addr_o, mem_addr_o;
  logic [DW-1:0]          c_read_data_o, mem_wdata_o, mem_rdata_i;
  logic                   mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i;

  nat_mem_arb #(.ADDR_W(AW), .NATIVE_DW(DW)) dut (
    .aclk_i(aclk_i), .aresetn_i(aresetn_i),
    .c_write_valid_i(c_write_valid_i), .c_write_addr_i(c_write_addr_i), .c_write_data_i(c_write_data_i),
    .c_read_valid_i(c_read_valid_i), .c_read_addr_i(c_read_addr_i),
    .c_read_valid_o(c_read_valid_o), .c_read_addr_o(c_read_addr_o), .c_read_data_o(c_read_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .ovf_o(ovf_o)
  );

  always #5 aclk_i = ~aclk_i;

  typedef struct {
    logic rst; logic [1:0] wv, rv; logic [AW-1:0] a0, a1; logic rdy, rvld; logic [AW-1:0] ret;
    logic e_req, e_we; logic [AW-1:0] e_addr; logic [1:0] e_rvo; logic [AW-1:0] e_raddr;
  } vec_t;
  vec_t tv[$];

  int nvec = 0, nerr = 0, nacc = 0, nrvo = 0, base;

  always @(posedge aclk_i) begin
    if (aresetn_i && mem_req_o && mem_ready_i) nacc <= nacc + 1;
    if (c_read_valid_o != 2'b00) nrvo <= nrvo + 1;
  end

  function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] wv, rv, input logic [AW-1:0] a0, a1,
                     input logic rdy, rvld, input logic [AW-1:0] ret, input logic e_req, e_we,
                     input logic [AW-1:0] e_addr, input logic [1:0] e_rvo, input logic [AW-1:0] e_raddr);
    tv.push_back('{rst, wv, rv, a0, a1, rdy, rvld, ret, e_req, e_we, e_addr, e_rvo, e_raddr});
  endtask

  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic idle_in();
    c_write_valid_i = '0;
    c_read_valid_i  = '0;
    mem_rvalid_i    = 1'b0;
    mem_rdata_i     = '0;
  endtask

  logic [AW-1:0] fa, sa;
  logic [1:0]    fo, so;

  initial begin
    idle_in();
    c_write_addr_i = '0; c_read_addr_i = '0; c_write_data_i = '0; mem_ready_i = 1'b1;
    fa = FIX ? 32'h200 : 32'h300;
    sa = FIX ? 32'h300 : 32'h200;
    fo = FIX ? 2'b01 : 2'b10;
    so = FIX ? 2'b10 : 2'b01;
    // write then read-after-write to 0x100, 2-cycle read latency
    add(0, 2'b01, 2'b00, 'h100, 0, 1, 0, 0,      0, 0, 0,      2'b00, 0);
    add(0, 2'b00, 2'b01, 'h100, 0, 1, 0, 0,      1, 1, 'h100,  2'b00, 0);
    add(0, 2'b00, 2'b00, 'h100, 0, 1, 0, 0,      0, 0, 0,      2'b00, 0);
    add(0, 2'b00, 2'b00, 'h100, 0, 1, 0, 0,      1, 0, 'h100,  2'b00, 0);
    add(0, 2'b00, 2'b00, 'h100, 0, 1, 0, 0,      0, 0, 0,      2'b00, 0);
    add(0, 2'b00, 2'b00, 'h100, 0, 1, 0, 0,      0, 0, 0,      2'b00, 0);
    add(0, 2'b00, 2'b00, 'h100, 0, 1, 1, 'h100,  0, 0, 0,      2'b01, 'h100);
    add(0, 2'b00, 2'b00, 'h100, 0, 1, 0, 0,      0, 0, 0,      2'b00, 'h100);
    // reset, then simultaneous reads from both clients, twice
    add(1, 2'b00, 2'b00, 0, 0, 1, 0, 0,          0, 0, 0,      2'b00, 0);
    add(0, 2'b00, 2'b11, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, 0);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  1, 0, 'h200,  2'b00, 0);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, 0);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 1, 'h200, 0, 0, 0,   2'b01, 'h200);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, 'h200);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  1, 0, 'h300,  2'b00, 'h200);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, 'h200);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 1, 'h300, 0, 0, 0,   2'b10, 'h300);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, 'h300);
    add(0, 2'b00, 2'b11, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, 'h300);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  1, 0, fa,     2'b00, 'h300);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, 'h300);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 1, fa, 0, 0, 0,      fo,    fa);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, fa);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  1, 0, sa,     2'b00, fa);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, fa);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 1, sa, 0, 0, 0,      so,    sa);
    add(0, 2'b00, 2'b00, 'h200, 'h300, 1, 0, 0,  0, 0, 0,      2'b00, sa);

    repeat (2) @(negedge aclk_i);
    nvec++;
    chk("rst_req", mem_req_o, 0); chk("rst_we", mem_we_o, 0); chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0); chk("rst_rvo", c_read_valid_o, 0); chk("rst_ovf", ovf_o, 0);
    chk("rst_raddr", c_read_addr_o, 0); chk("rst_rdata", c_read_data_o, 0);

    foreach (tv[i]) begin
      @(negedge aclk_i);
      aresetn_i = !tv[i].rst;
      c_write_valid_i = tv[i].wv; c_read_valid_i = tv[i].rv;
      c_write_addr_i[0] = tv[i].a0; c_write_data_i[0] = mk(tv[i].a0); c_read_addr_i[0] = tv[i].a0;
      c_write_addr_i[1] = tv[i].a1; c_write_data_i[1] = mk(tv[i].a1); c_read_addr_i[1] = tv[i].a1;
      mem_ready_i = tv[i].rdy; mem_rvalid_i = tv[i].rvld;
      mem_rdata_i = tv[i].rvld ? mk(tv[i].ret) : '0;
      tick();
      nvec++;
      chk($sformatf("v%0d_req", i), mem_req_o, tv[i].e_req);
      if (tv[i].e_req || tv[i].rst) begin
        chk($sformatf("v%0d_we", i), mem_we_o, tv[i].e_we);
        chk($sformatf("v%0d_addr", i), mem_addr_o, tv[i].e_addr);
        chk($sformatf("v%0d_wdata", i), mem_wdata_o, tv[i].e_we ? mk(tv[i].e_addr) : '0);
      end
      chk($sformatf("v%0d_rvo", i), c_read_valid_o, tv[i].e_rvo);
      chk($sformatf("v%0d_raddr", i), c_read_addr_o, tv[i].e_raddr);
      chk($sformatf("v%0d_rdata", i), c_read_data_o, (tv[i].e_raddr == 0) ? '0 : mk(tv[i].e_raddr));
      chk($sformatf("v%0d_ovf", i), ovf_o, 0);
    end

    // write held off by memory for 5 cycles
    @(negedge aclk_i);
    idle_in();
    base = nacc;
    c_write_valid_i = 2'b10; c_write_addr_i[1] = 'h400; c_write_data_i[1] = mk('h400); mem_ready_i = 1'b0;
    tick();
    @(negedge aclk_i); c_write_valid_i = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      chk("stall_req", mem_req_o, 1); chk("stall_we", mem_we_o, 1);
      chk("stall_addr", mem_addr_o, 'h400); chk("stall_wdata", mem_wdata_o, mk('h400));
    end
    @(negedge aclk_i); mem_ready_i = 1'b1;
    tick(); tick(); tick();
    nvec++;
    chk("stall_drop_req", mem_req_o, 0); chk("stall_accepts", nacc - base, 1);

    // accept and new pulse to the same slot on one edge
    @(negedge aclk_i);
    c_write_valid_i = 2'b01; c_write_addr_i[0] = 'h700; c_write_data_i[0] = mk('h700); mem_ready_i = 1'b0;
    tick();
    @(negedge aclk_i); c_write_valid_i = '0;
    tick();
    nvec++;
    chk("same_req1", mem_req_o, 1); chk("same_addr1", mem_addr_o, 'h700);
    @(negedge aclk_i);
    c_write_valid_i = 2'b01; c_write_addr_i[0] = 'h710; c_write_data_i[0] = mk('h710); mem_ready_i = 1'b1;
    tick();
    nvec++;
    chk("same_gap", mem_req_o, 0);
    @(negedge aclk_i); c_write_valid_i = '0;
    tick();
    nvec++;
    chk("same_req2", mem_req_o, 1); chk("same_addr2", mem_addr_o, 'h710);
    chk("same_wdata2", mem_wdata_o, mk('h710)); chk("same_ovf", ovf_o, 0);
    tick();

    // back-to-back client 1 writes while memory stalls
    @(negedge aclk_i);
    base = nacc;
    c_write_valid_i = 2'b10; c_write_addr_i[1] = 'h500; c_write_data_i[1] = mk('h500); mem_ready_i = 1'b0;
    tick();
    @(negedge aclk_i);
    c_write_addr_i[1] = 'h600; c_write_data_i[1] = mk('h600);
    tick();
    nvec++;
    chk("ovf_flag", ovf_o, 2'b10); chk("ovf_req", mem_req_o, 1); chk("ovf_addr", mem_addr_o, 'h500);
    @(negedge aclk_i); c_write_valid_i = '0;
    tick(); tick();
    nvec++;
    chk("ovf_hold_addr", mem_addr_o, 'h500); chk("ovf_hold_wdata", mem_wdata_o, mk('h500));
    @(negedge aclk_i); mem_ready_i = 1'b1;
    repeat (5) tick();
    nvec++;
    chk("ovf_accepts", nacc - base, 1); chk("ovf_idle", mem_req_o, 0); chk("ovf_sticky", ovf_o, 2'b10);

    // reset while waiting for read data, then a late rvalid
    @(negedge aclk_i);
    c_read_valid_i = 2'b01; c_read_addr_i[0] = 'h800;
    tick();
    @(negedge aclk_i); c_read_valid_i = '0;
    tick();
    nvec++;
    chk("rw_req", mem_req_o, 1); chk("rw_addr", mem_addr_o, 'h800);
    tick();
    nvec++;
    chk("rw_wait", mem_req_o, 0);
    #2 aresetn_i = 1'b0;
    #1;
    nvec++;
    chk("arst_ovf", ovf_o, 0); chk("arst_we", mem_we_o, 0); chk("arst_addr", mem_addr_o, 0);
    chk("arst_raddr", c_read_addr_o, 0); chk("arst_rdata", c_read_data_o, 0);
    @(negedge aclk_i); aresetn_i = 1'b1;
    base = nrvo;
    @(negedge aclk_i); mem_rvalid_i = 1'b1; mem_rdata_i = mk('h800);
    @(negedge aclk_i); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (4) tick();
    nvec++;
    chk("late_rvo", nrvo - base, 0); chk("late_req", mem_req_o, 0); chk("late_raddr", c_read_addr_o, 0);
    chk("late_rdata", c_read_data_o, 0); chk("late_wdata", mem_wdata_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
